// File: rtl/bram_dp_param_pkg.sv
// Shared types and helpers for the parametrised dual-port BRAM.
// Clear-sequencer state encoding, write-mode constants and a constant clog2.
package bram_dp_param_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset memory clear sequencer: walks every word once, writing zero,
// and holds busy_o high until the last word has been cleared.
module bram_clear_seq
  import bram_dp_param_pkg::*;
#(
  parameter int DEPTH = 11,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [CNT_W-1:0] clr_addr_o
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // The word at cnt_q is written this cycle; stop after the last one.
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = busy_q;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/bram_dp_param.sv
// Parametrised dual-port BRAM: port A read/write with byte enables, port B read-only.
// Optional collision flag output COLL enabled by BRAM_DP_COLLISION_CHK_EN.
module bram_dp_param
  import bram_dp_param_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 11,
  parameter int ADDR_W     = 12,
  parameter int READ_LAT   = 1,
  parameter int WRITE_MODE = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENA,
  input  logic [DATA_W/8-1:0] WEA,
  input  logic [ADDR_W-1:0]   AA,
  input  logic [DATA_W-1:0]   DiA,
  output logic [DATA_W-1:0]   DoA,
  input  logic                ENB,
  input  logic [ADDR_W-1:0]   AB,
  output logic [DATA_W-1:0]   DoB,
  output logic                BUSY,
  output logic                OOR
`ifdef BRAM_DP_COLLISION_CHK_EN
  ,
  output logic                COLL
`endif
);

  localparam int BYTES       = DATA_W / 8;
  localparam int OFF_W       = clog2(BYTES);
  localparam int CNT_W       = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam bit WRITE_FIRST = (WRITE_MODE == WM_WRITE_FIRST);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [CNT_W-1:0]  clr_addr;

  logic [ADDR_W-1:0] idx_a, idx_b;
  logic [CNT_W-1:0]  wa, wb;
  logic              in_a, in_b;
  logic [DATA_W-1:0] merged_a;

  logic [DATA_W-1:0] doa_p1_q, dob_p1_q;
  logic              oor_p1_q;

  bram_clear_seq #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_clear_seq (
    .clk_i      (CLK),
    .rst_i      (RST),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign idx_a = AA >> OFF_W;
  assign idx_b = AB >> OFF_W;
  assign in_a  = idx_a < ADDR_W'(DEPTH);
  assign in_b  = idx_b < ADDR_W'(DEPTH);
  assign wa    = idx_a[CNT_W-1:0];
  assign wb    = idx_b[CNT_W-1:0];

  always_comb begin
    merged_a = mem_q[wa];
    for (int i = 0; i < BYTES; i++) begin
      if (WEA[i]) merged_a[8*i +: 8] = DiA[8*i +: 8];
    end
  end

  // Clear sequencer owns the write port while busy; port A is locked out.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (!RST && ENA && in_a) begin
      for (int i = 0; i < BYTES; i++) begin
        if (WEA[i]) mem_q[wa][8*i +: 8] <= DiA[8*i +: 8];
      end
    end
  end

  // Stage p1: array read; Do holds when its enable is low.
  always_ff @(posedge CLK) begin
    if (RST || busy) begin
      doa_p1_q <= '0;
      dob_p1_q <= '0;
      oor_p1_q <= 1'b0;
    end else begin
      oor_p1_q <= (ENA && !in_a) || (ENB && !in_b);
      if (ENA) doa_p1_q <= in_a ? (WRITE_FIRST ? merged_a : mem_q[wa]) : '0;
      if (ENB) dob_p1_q <= in_b ? mem_q[wb] : '0;
    end
  end

  // Stage p2: optional output register for READ_LAT=2.
  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] doa_p2_q, dob_p2_q;
      logic              oor_p2_q;
      always_ff @(posedge CLK) begin
        if (RST) begin
          doa_p2_q <= '0;
          dob_p2_q <= '0;
          oor_p2_q <= 1'b0;
        end else begin
          doa_p2_q <= doa_p1_q;
          dob_p2_q <= dob_p1_q;
          oor_p2_q <= oor_p1_q;
        end
      end
      assign DoA = doa_p2_q;
      assign DoB = dob_p2_q;
      assign OOR = oor_p2_q;
    end else begin : g_lat1
      assign DoA = doa_p1_q;
      assign DoB = dob_p1_q;
      assign OOR = oor_p1_q;
    end
  endgenerate

  assign BUSY = busy;

`ifdef BRAM_DP_COLLISION_CHK_EN
  logic coll_now;
  logic coll_p1_q;

  assign coll_now = ENA && (|WEA) && ENB && in_a && in_b && (wa == wb);

  always_ff @(posedge CLK) begin
    if (RST || busy) coll_p1_q <= 1'b0;
    else             coll_p1_q <= coll_now;
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (!RST && !busy && coll_now)
      $display("bram_dp_param: warning, port A write and port B read hit word %0d", wa);
  end
`endif

  generate
    if (READ_LAT == 2) begin : g_coll2
      logic coll_p2_q;
      always_ff @(posedge CLK) begin
        if (RST) coll_p2_q <= 1'b0;
        else     coll_p2_q <= coll_p1_q;
      end
      assign COLL = coll_p2_q;
    end else begin : g_coll1
      assign COLL = coll_p1_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_bram_dp_param.sv
// Bench for bram_dp_param: one read-first/latency-1 instance and one
// write-first/latency-2 instance share stimulus and a behavioural memory model.
module tb_bram_dp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena, enb;
  logic [3:0]  wea;
  logic [11:0] aa, ab;
  logic [31:0] dia;
  logic [31:0] doa1, dob1, doa2, dob2;
  logic        busy1, busy2, oor1, oor2;
`ifdef BRAM_DP_COLLISION_CHK_EN
  logic        coll1, coll2;
`endif

  bram_dp_param #(.DATA_W(32), .DEPTH(11), .ADDR_W(12), .READ_LAT(1), .WRITE_MODE(0)) dut1 (
    .CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .AA(aa), .DiA(dia), .DoA(doa1),
    .ENB(enb), .AB(ab), .DoB(dob1), .BUSY(busy1), .OOR(oor1)
`ifdef BRAM_DP_COLLISION_CHK_EN
    , .COLL(coll1)
`endif
  );

  bram_dp_param #(.DATA_W(32), .DEPTH(11), .ADDR_W(12), .READ_LAT(2), .WRITE_MODE(1)) dut2 (
    .CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .AA(aa), .DiA(dia), .DoA(doa2),
    .ENB(enb), .AB(ab), .DoB(dob2), .BUSY(busy2), .OOR(oor2)
`ifdef BRAM_DP_COLLISION_CHK_EN
    , .COLL(coll2)
`endif
  );

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: memory contents, clear progress, and the read result
  // each instance should present after the most recent clock edge.
  logic [31:0] m_mem [11];
  bit          m_busy;
  int          m_cnt;
  logic [31:0] m_a_rf, m_a_wf, m_b, m_a2, m_b2;
  bit          m_oor1, m_oor2, m_coll1, m_coll2;

  task automatic model_edge();
    int ia, ib;
    logic [31:0] nw;
    if (rst) begin
      m_busy = 1; m_cnt = 0;
      m_a_rf = 0; m_a_wf = 0; m_b = 0; m_a2 = 0; m_b2 = 0;
      m_oor1 = 0; m_oor2 = 0; m_coll1 = 0; m_coll2 = 0;
      return;
    end
    m_a2 = m_a_wf; m_b2 = m_b; m_oor2 = m_oor1; m_coll2 = m_coll1;
    if (m_busy) begin
      m_mem[m_cnt] = 0;
      m_a_rf = 0; m_a_wf = 0; m_b = 0; m_oor1 = 0; m_coll1 = 0;
      if (m_cnt == 10) m_busy = 0;
      else m_cnt++;
    end else begin
      ia = int'(aa >> 2);
      ib = int'(ab >> 2);
      m_oor1  = (ena && ia >= 11) || (enb && ib >= 11);
      m_coll1 = ena && (wea != 0) && enb && ia < 11 && ib < 11 && ia == ib;
      if (enb) m_b = (ib < 11) ? m_mem[ib] : 32'h0;
      if (ena) begin
        if (ia < 11) begin
          nw = m_mem[ia];
          for (int b = 0; b < 4; b++) if (wea[b]) nw[8*b +: 8] = dia[8*b +: 8];
          m_a_rf = m_mem[ia];
          m_a_wf = nw;
          m_mem[ia] = nw;
        end else begin
          m_a_rf = 0;
          m_a_wf = 0;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 0; enb = 0; wea = 0;
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1; idle(); aa = 0; ab = 0; dia = 0;
    step();
    n_run++; if (doa1 !== 32'h0) begin n_fail++; $display("FAIL reset_doa got %h want 0", doa1); end
    n_run++; if (dob1 !== 32'h0) begin n_fail++; $display("FAIL reset_dob got %h want 0", dob1); end
    n_run++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy1); end
    n_run++; if (oor1 !== 1'b0) begin n_fail++; $display("FAIL reset_oor got %b want 0", oor1); end
    n_run++; if (doa2 !== 32'h0 || dob2 !== 32'h0) begin n_fail++; $display("FAIL reset_do_lat2 got %h/%h want 0/0", doa2, dob2); end
    rst = 0; cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!busy1) begin cyc = i; break; end
    end
    n_run++; if (cyc != 11) begin n_fail++; $display("FAIL reset_busy_cycles got %0d want 11", cyc); end
    n_run++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_lat2 got %b want 0", busy2); end
  endtask

  task automatic test_clear_zero();
    int cyc;
    for (int i = 0; i < 30; i++) begin
      ena = 1; wea = 4'hF; aa = 12'(4 * $urandom_range(0, 10)); dia = $urandom;
      step();
    end
    idle();
    rst = 1; step(); rst = 0;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!busy1) begin cyc = i; break; end
    end
    n_run++; if (cyc != 11) begin n_fail++; $display("FAIL clear_busy_cycles got %0d want 11", cyc); end
    for (int w = 0; w < 11; w++) begin
      enb = 1; ab = 12'(4 * w); ena = 1; wea = 0; aa = 12'(4 * w);
      step();
      n_run++; if (dob1 !== 32'h0) begin n_fail++; $display("FAIL clear_word_b w%0d got %h want 0", w, dob1); end
      n_run++; if (doa1 !== 32'h0) begin n_fail++; $display("FAIL clear_word_a w%0d got %h want 0", w, doa1); end
    end
    idle(); step();
  endtask

  task automatic test_byte_en();
    ena = 1; wea = 4'hF; aa = 12'h008; dia = 32'hAABBCCDD; step();
    wea = 4'b0101; dia = 32'h11223344; step();
    idle(); enb = 1; ab = 12'h008; step();
    n_run++; if (dob1 !== 32'hAA22CC44) begin n_fail++; $display("FAIL byte_en got %h want aa22cc44", dob1); end
    n_run++; if (dob1 !== m_b) begin n_fail++; $display("FAIL byte_en_model got %h want %h", dob1, m_b); end
    idle(); step();
  endtask

  task automatic test_latency_mode();
    ena = 1; wea = 4'hF; aa = 12'h00C; dia = 32'h99; step();
    idle(); step(); step();
    ena = 1; wea = 4'hF; aa = 12'h00C; dia = 32'h5; step();
    n_run++; if (doa1 !== 32'h99) begin n_fail++; $display("FAIL rf_lat1_doa got %h want 99", doa1); end
    n_run++; if (doa2 !== 32'h99) begin n_fail++; $display("FAIL wf_lat2_early got %h want 99 (previous read)", doa2); end
    idle(); step();
    n_run++; if (doa2 !== 32'h5) begin n_fail++; $display("FAIL wf_lat2_doa got %h want 5", doa2); end
    n_run++; if (doa1 !== 32'h99) begin n_fail++; $display("FAIL rf_hold_doa got %h want 99", doa1); end
    step();
  endtask

  task automatic test_collision();
    ena = 1; wea = 4'hF; aa = 12'h010; dia = 32'h12345678; step();
    idle(); step();
    ena = 1; wea = 4'hF; aa = 12'h010; dia = 32'h77; enb = 1; ab = 12'h010; step();
    n_run++; if (dob1 !== 32'h12345678) begin n_fail++; $display("FAIL coll_dob_old got %h want 12345678", dob1); end
`ifdef BRAM_DP_COLLISION_CHK_EN
    n_run++; if (coll1 !== 1'b1) begin n_fail++; $display("FAIL coll_flag got %b want 1", coll1); end
`endif
    ena = 0; wea = 0; step();
    n_run++; if (dob1 !== 32'h77) begin n_fail++; $display("FAIL coll_dob_new got %h want 77", dob1); end
    n_run++; if (dob2 !== 32'h12345678) begin n_fail++; $display("FAIL coll_dob_lat2 got %h want 12345678", dob2); end
    n_run++; if (doa2 !== 32'h77) begin n_fail++; $display("FAIL coll_doa_wf got %h want 77", doa2); end
`ifdef BRAM_DP_COLLISION_CHK_EN
    n_run++; if (coll1 !== 1'b0 || coll2 !== 1'b1) begin n_fail++; $display("FAIL coll_pulse got %b/%b want 0/1", coll1, coll2); end
`endif
    idle(); step();
  endtask

  task automatic test_oor();
    logic [31:0] snap [11];
    idle(); enb = 1; ab = 12'h02C; step();
    n_run++; if (dob1 !== 32'h0) begin n_fail++; $display("FAIL oor_read_dob got %h want 0", dob1); end
    n_run++; if (oor1 !== 1'b1) begin n_fail++; $display("FAIL oor_read_flag got %b want 1", oor1); end
    enb = 0; step();
    n_run++; if (oor1 !== 1'b0) begin n_fail++; $display("FAIL oor_pulse_end got %b want 0", oor1); end
    n_run++; if (oor2 !== 1'b1) begin n_fail++; $display("FAIL oor_lat2_flag got %b want 1", oor2); end
    for (int w = 0; w < 11; w++) snap[w] = m_mem[w];
    ena = 1; wea = 4'hF; aa = 12'h030; dia = 32'hDEADBEEF; step();
    n_run++; if (oor1 !== 1'b1) begin n_fail++; $display("FAIL oor_write_flag got %b want 1", oor1); end
    idle();
    for (int w = 0; w < 11; w++) begin
      enb = 1; ab = 12'(4 * w); step();
      n_run++; if (dob1 !== snap[w]) begin n_fail++; $display("FAIL oor_mem_unchanged w%0d got %h want %h", w, dob1, snap[w]); end
    end
    idle(); step();
  endtask

  task automatic test_reset_mid_clear();
    int cyc;
    rst = 1; step(); rst = 0;
    ena = 1; wea = 4'hF; aa = 12'h000; dia = 32'hFFFFFFFF; enb = 1; ab = 12'h02C;
    for (int i = 0; i < 5; i++) begin
      step();
      n_run++; if (doa1 !== 0 || dob1 !== 0 || oor1 !== 0 || busy1 !== 1) begin
        n_fail++; $display("FAIL busy_ignore c%0d got doa=%h dob=%h oor=%b busy=%b want 0/0/0/1", i, doa1, dob1, oor1, busy1);
      end
    end
    rst = 1; step(); rst = 0;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      n_run++; if (oor1 !== 1'b0 || doa1 !== 32'h0) begin n_fail++; $display("FAIL restart_ignore c%0d got oor=%b doa=%h want 0/0", i, oor1, doa1); end
      if (!busy1) begin cyc = i; break; end
    end
    n_run++; if (cyc != 11) begin n_fail++; $display("FAIL restart_busy_cycles got %0d want 11", cyc); end
    idle(); enb = 1; ab = 12'h000; step();
    n_run++; if (dob1 !== 32'h0) begin n_fail++; $display("FAIL restart_word0 got %h want 0", dob1); end
    idle(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      ena = 1'($urandom_range(0, 1)); wea = 4'($urandom); dia = $urandom;
      aa  = 12'($urandom_range(0, 'h3F));
      enb = 1'($urandom_range(0, 1)); ab = 12'($urandom_range(0, 'h3F));
      if ($urandom_range(0, 3) == 0) ab = aa;
      step();
      n_run++; if (doa1 !== m_a_rf) begin n_fail++; $display("FAIL rand_doa1 i%0d got %h want %h", i, doa1, m_a_rf); end
      n_run++; if (dob1 !== m_b) begin n_fail++; $display("FAIL rand_dob1 i%0d got %h want %h", i, dob1, m_b); end
      n_run++; if (oor1 !== m_oor1) begin n_fail++; $display("FAIL rand_oor1 i%0d got %b want %b", i, oor1, m_oor1); end
      n_run++; if (doa2 !== m_a2) begin n_fail++; $display("FAIL rand_doa2 i%0d got %h want %h", i, doa2, m_a2); end
      n_run++; if (dob2 !== m_b2) begin n_fail++; $display("FAIL rand_dob2 i%0d got %h want %h", i, dob2, m_b2); end
      n_run++; if (oor2 !== m_oor2) begin n_fail++; $display("FAIL rand_oor2 i%0d got %b want %b", i, oor2, m_oor2); end
      n_run++; if (busy1 !== m_busy) begin n_fail++; $display("FAIL rand_busy i%0d got %b want %b", i, busy1, m_busy); end
`ifdef BRAM_DP_COLLISION_CHK_EN
      n_run++; if (coll1 !== m_coll1 || coll2 !== m_coll2) begin n_fail++; $display("FAIL rand_coll i%0d got %b/%b want %b/%b", i, coll1, coll2, m_coll1, m_coll2); end
`endif
    end
    idle(); step();
  endtask

  initial begin
    rst = 1; ena = 0; enb = 0; wea = 0; aa = 0; ab = 0; dia = 0;
    test_reset();
    test_byte_en();
    test_latency_mode();
    test_collision();
    test_oor();
    test_clear_zero();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
